// File: rtl/i2c_eeprom_slave_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave_ctrl
//
// I2C slave protocol engine for the on-chip EEPROM.  SCL/SDA are oversampled
// in the clk domain, START/STOP are detected, and the controller sequences
// device-address match, word-address load, byte writes and sequential reads
// against a synchronous memory (read data valid 1 clk after an address change).
// ACK and read data leave through an open-drain enable.
//
// Parameters
//   DEV_ADDR     7-bit slave address
//   ADDR_W       memory word-address width (<= 8), taken from the low bits
//                of the word-address byte
//   PAGE_SIZE    write page length in bytes (power of two)
//   SYNC_STAGES  synchronizer depth on scl_in/sda_in
//
// Ports
//   clk        system clock (only clock)
//   rst_n      asynchronous active-low reset
//   scl_in     raw I2C clock pin
//   sda_in     raw I2C data pin
//   sda_oe     1 = pull SDA low, 0 = release
//   mem_addr   memory address pointer
//   mem_wdata  write byte
//   mem_we     one-cycle write strobe
//   mem_rdata  memory data at mem_addr
//   busy       high from address match until STOP or master NACK
//
// Build option
//   I2C_EEPROM_PAGE_WRAP_EN  when defined, write auto-increment rolls over
//                            inside the PAGE_SIZE-aligned page; reads always
//                            wrap over the whole array.
// ---------------------------------------------------------------------------
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | bus free, waiting for START
// DEVADDR   | shifting in the device-address byte
// ACK_DEV   | driving ACK for a matched device address
// WORDADDR  | shifting in the word-address byte
// ACK_WA    | driving ACK for the word address
// WRITE     | shifting in a data byte to be written
// ACK_WR    | driving ACK for a written byte
// READ      | shifting a memory byte out on SDA
// RACK      | master ACK/NACK slot after a read byte
// IGNORE    | not addressed / after NACK, waiting for START or STOP
// ---------------------------------------------------------------------------
module i2c_eeprom_slave_ctrl #(
   parameter logic [6:0] DEV_ADDR    = 7'h50,
   parameter int         ADDR_W      = 8,
   parameter int         PAGE_SIZE   = 8,
   parameter int         SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   typedef enum logic [3:0] {
      IDLE,
      DEVADDR,
      ACK_DEV,
      WORDADDR,
      ACK_WA,
      WRITE,
      ACK_WR,
      READ,
      RACK,
      IGNORE
   } state_t;

   localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_SIZE - 1);
`ifdef I2C_EEPROM_PAGE_WRAP_EN
   // only the in-page offset bits roll over on a write increment
   localparam logic [ADDR_W-1:0] WR_WRAP_MASK = PAGE_MASK;
`else
   // every address bit rolls over: linear increment across the whole array
   localparam logic [ADDR_W-1:0] WR_WRAP_MASK = PAGE_MASK | ~PAGE_MASK;
`endif

   // ------------------------------------------------------------------
   // pin synchronizers + history flops
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_d;
   logic                   sda_d;
   logic                   s_scl;
   logic                   s_sda;

   // reset to the idle-bus level so release from reset creates no edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync[0] <= scl_in;
         sda_sync[0] <= sda_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            scl_sync[i] <= scl_sync[i-1];
            sda_sync[i] <= sda_sync[i-1];
         end
         scl_d <= s_scl;
         sda_d <= s_sda;
      end
   end

   assign s_scl = scl_sync[SYNC_STAGES-1];
   assign s_sda = sda_sync[SYNC_STAGES-1];

   logic scl_rise;
   logic scl_fall;
   logic start;
   logic stop;

   assign scl_rise = s_scl & ~scl_d;
   assign scl_fall = ~s_scl & scl_d;
   assign start    = s_scl & sda_d & ~s_sda;
   assign stop     = s_scl & ~sda_d & s_sda;

   // ------------------------------------------------------------------
   // address increment
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] addr_wr_next;

   assign addr_inc     = mem_addr + ADDR_W'(1);
   assign addr_wr_next = (mem_addr & ~WR_WRAP_MASK) | (addr_inc & WR_WRAP_MASK);

   // ------------------------------------------------------------------
   // protocol FSM
   // ------------------------------------------------------------------
   state_t     state;
   logic [7:0] shreg;
   logic [3:0] bit_cnt;
   logic       rw;
   logic       wr_inc_pend;
   logic       byte_done;

   // the 8th bit has been sampled and SCL is falling into the ACK slot
   assign byte_done = scl_fall && (bit_cnt == 4'd8);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         shreg       <= 8'h00;
         bit_cnt     <= 4'd0;
         rw          <= 1'b0;
         wr_inc_pend <= 1'b0;
         sda_oe      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= 8'h00;
         mem_we      <= 1'b0;
         busy        <= 1'b0;
      end else begin
         mem_we <= 1'b0;

         // write pointer advances the clk after the strobe
         if (wr_inc_pend) begin
            mem_addr    <= addr_wr_next;
            wr_inc_pend <= 1'b0;
         end

         if (stop) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else if (start) begin
            // repeated start keeps mem_addr so a random read can follow
            state   <= DEVADDR;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
               end

               DEVADDR: begin
                  if (scl_rise) begin
                     shreg   <= {shreg[6:0], s_sda};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (byte_done) begin
                     bit_cnt <= 4'd0;
                     if (shreg[7:1] == DEV_ADDR) begin
                        state  <= ACK_DEV;
                        rw     <= shreg[0];
                        busy   <= 1'b1;
                        sda_oe <= 1'b1;
                     end else begin
                        state <= IGNORE;
                        busy  <= 1'b0;
                     end
                  end
               end

               ACK_DEV: begin
                  if (scl_fall) begin
                     if (rw) begin
                        state   <= READ;
                        shreg   <= mem_rdata;
                        sda_oe  <= ~mem_rdata[7];
                        bit_cnt <= 4'd0;
                     end else begin
                        state  <= WORDADDR;
                        sda_oe <= 1'b0;
                     end
                  end
               end

               WORDADDR: begin
                  if (scl_rise) begin
                     shreg   <= {shreg[6:0], s_sda};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (byte_done) begin
                     bit_cnt  <= 4'd0;
                     mem_addr <= shreg[ADDR_W-1:0];
                     sda_oe   <= 1'b1;
                     state    <= ACK_WA;
                  end
               end

               ACK_WA: begin
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     state  <= WRITE;
                  end
               end

               WRITE: begin
                  if (scl_rise) begin
                     shreg   <= {shreg[6:0], s_sda};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (byte_done) begin
                     bit_cnt     <= 4'd0;
                     mem_wdata   <= shreg;
                     mem_we      <= 1'b1;
                     wr_inc_pend <= 1'b1;
                     sda_oe      <= 1'b1;
                     state       <= ACK_WR;
                  end
               end

               ACK_WR: begin
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     state  <= WRITE;
                  end
               end

               // shreg[7] is already on the bus; each fall shifts the next
               // bit up, and the fall after the 8th rise frees the ACK slot
               READ: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        bit_cnt <= 4'd0;
                        sda_oe  <= 1'b0;
                        state   <= RACK;
                     end else begin
                        shreg  <= {shreg[6:0], 1'b0};
                        sda_oe <= ~shreg[6];
                     end
                  end
               end

               // a fall in RACK can only follow an ACKed 9th rise, by which
               // time mem_rdata already reflects the incremented address
               RACK: begin
                  if (scl_rise) begin
                     if (!s_sda) begin
                        mem_addr <= addr_inc;
                     end else begin
                        state  <= IGNORE;
                        busy   <= 1'b0;
                        sda_oe <= 1'b0;
                     end
                  end else if (scl_fall) begin
                     state   <= READ;
                     shreg   <= mem_rdata;
                     sda_oe  <= ~mem_rdata[7];
                     bit_cnt <= 4'd0;
                  end
               end

               IGNORE: begin
               end

               default: begin
                  state  <= IDLE;
                  sda_oe <= 1'b0;
                  busy   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_eeprom_slave_ctrl.sv
module tb_i2c_eeprom_slave_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_oe;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic [7:0] mem_rdata;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;

   assign sda_line = sda_m & ~sda_oe;

   i2c_eeprom_slave_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_in    (scl_m),
      .sda_in    (sda_line),
      .sda_oe    (sda_oe),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // synchronous memory attached to the DUT
   logic [7:0] mem [256];
   logic       pre_we = 1'b0;
   logic [7:0] pre_addr = 8'h00;
   logic [7:0] pre_data = 8'h00;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else if (pre_we) mem[pre_addr] <= pre_data;
      mem_rdata <= mem[mem_addr];
   end

   // reference model: array contents, address pointer, expected writes
   logic [7:0]  exp_mem [256];
   int          ptr = 0;
   logic [15:0] exp_wq[$];
   logic [7:0]  we_log[$];
   logic        slave_ok = 1'b0;
   logic        we_prev = 1'b0;
   logic [15:0] we_exp;

   function automatic int next_wr(input int a);
`ifdef I2C_EEPROM_PAGE_WRAP_EN
      return (a / 8) * 8 + (a + 1) % 8;
`else
      return (a + 1) % 256;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle compare: write strobes against the model, bus release
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_we) begin
            we_log.push_back(mem_addr);
            chk("we_one_clk", {31'b0, we_prev}, 0);
            if (exp_wq.size() == 0) begin
               chk("unexpected_we", {24'b0, mem_addr}, 32'hffff_ffff);
            end else begin
               we_exp = exp_wq.pop_front();
               chk("we_addr", mem_addr, we_exp[15:8]);
               chk("we_data", mem_wdata, we_exp[7:0]);
            end
         end
         if (scl_m && !slave_ok) chk("sda_oe_released", sda_oe, 0);
      end
      we_prev <= mem_we;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

   // ---------------- bus master ----------------
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clock_bit(input logic v, input logic may_drive, output logic s);
      slave_ok = may_drive;
      wait_n(5); sda_m = v;
      wait_n(5); scl_m = 1'b1;
      wait_n(5); s = sda_line;
      wait_n(5); scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      slave_ok = 1'b0;
      wait_n(5); sda_m = 1'b1;
      wait_n(5); scl_m = 1'b1;
      wait_n(5); sda_m = 1'b0;
      wait_n(5); scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      slave_ok = 1'b0;
      wait_n(5); sda_m = 1'b0;
      wait_n(5); scl_m = 1'b1;
      wait_n(5); sda_m = 1'b1;
      wait_n(10);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic may_ack, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], 1'b0, s);
      clock_bit(1'b1, may_ack, s);
      ack = ~s;
   endtask

   task automatic recv_byte(output logic [7:0] b, input logic nack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, 1'b1, s);
         b[i] = s;
      end
      clock_bit(nack, 1'b0, s);
   endtask

   // ---------------- transactions ----------------
   task automatic do_write(input logic [6:0] dev, input logic [7:0] wa, input logic [7:0] dq[$]);
      logic ack;
      logic match;
      match = (dev == 7'h50);
      i2c_start();
      send_byte({dev, 1'b0}, match, ack);
      chk("dev_ack", ack, match);
      if (!match) begin
         chk("busy_unmatched", busy, 0);
         i2c_stop();
         chk("addr_unmatched", mem_addr, ptr);
         return;
      end
      chk("busy_matched", busy, 1);
      send_byte(wa, 1'b1, ack);
      chk("wa_ack", ack, 1);
      ptr = wa;
      for (int k = 0; k < dq.size(); k++) begin
         exp_wq.push_back({8'(ptr), dq[k]});
         exp_mem[ptr] = dq[k];
         ptr = next_wr(ptr);
         send_byte(dq[k], 1'b1, ack);
         chk("wr_ack", ack, 1);
      end
      i2c_stop();
      chk("busy_after_stop", busy, 0);
      chk("addr_after_write", mem_addr, ptr);
      chk("writes_drained", exp_wq.size(), 0);
   endtask

   task automatic do_read(input logic set_addr, input logic [7:0] wa, input int n,
                          output logic [7:0] got[$]);
      logic ack;
      logic [7:0] b;
      got.delete();
      if (set_addr) begin
         i2c_start();
         send_byte(8'hA0, 1'b1, ack);
         chk("rd_dev_w_ack", ack, 1);
         send_byte(wa, 1'b1, ack);
         chk("rd_wa_ack", ack, 1);
         ptr = wa;
      end
      i2c_start();
      send_byte(8'hA1, 1'b1, ack);
      chk("rd_dev_r_ack", ack, 1);
      chk("busy_read", busy, 1);
      for (int k = 0; k < n; k++) begin
         recv_byte(b, k == n - 1);
         got.push_back(b);
         chk("rd_data", b, exp_mem[ptr]);
         if (k != n - 1) ptr = (ptr + 1) % 256;
      end
      wait_n(8);
      chk("oe_after_nack", sda_oe, 0);
      chk("busy_after_nack", busy, 0);
      i2c_stop();
      chk("addr_after_read", mem_addr, ptr);
   endtask

   task automatic do_partial(input logic [7:0] wa);
      logic ack;
      logic s;
      i2c_start();
      send_byte(8'hA0, 1'b1, ack);
      chk("part_dev_ack", ack, 1);
      send_byte(wa, 1'b1, ack);
      chk("part_wa_ack", ack, 1);
      ptr = wa;
      for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), 1'b0, s);
      i2c_stop();
      chk("part_busy", busy, 0);
      chk("part_oe", sda_oe, 0);
      chk("part_addr", mem_addr, ptr);
      chk("part_no_we", exp_wq.size(), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] dq[$];
      logic [7:0] got[$];
      logic [7:0] v;
      logic       ack;
      logic       s;
      int         kind;

      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         v = (i == 8'h11) ? 8'h5A : 8'($urandom);
         pre_we = 1'b1; pre_addr = 8'(i); pre_data = v;
         exp_mem[i] = v;
      end
      @(negedge clk);
      pre_we = 1'b0;

      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      wait_n(10);

      // single write of 0x3C to 0x10
      dq = '{8'h3C};
      do_write(7'h50, 8'h10, dq);
      chk("lit_mem10", mem[8'h10], 8'h3C);
      chk("lit_wdata", mem_wdata, 8'h3C);
      chk("lit_addr11", mem_addr, 8'h11);

      // random read from 0x10: 0x3C then 0x5A
      do_read(1'b1, 8'h10, 2, got);
      chk("lit_rd0", got[0], 8'h3C);
      chk("lit_rd1", got[1], 8'h5A);

      // address mismatch 0xA2
      do_write(7'h51, 8'h00, dq);

      // three writes from 0x16
      we_log.delete();
      dq = '{8'h11, 8'h22, 8'h33};
      do_write(7'h50, 8'h16, dq);
      chk("lit_pw_cnt", we_log.size(), 3);
      chk("lit_pw0", we_log[0], 8'h16);
      chk("lit_pw1", we_log[1], 8'h17);
`ifdef I2C_EEPROM_PAGE_WRAP_EN
      chk("lit_pw2", we_log[2], 8'h10);
      chk("lit_pw_end", mem_addr, 8'h11);
`else
      chk("lit_pw2", we_log[2], 8'h18);
      chk("lit_pw_end", mem_addr, 8'h19);
`endif

      // STOP after four data bits
      do_partial(8'h40);

      // reset while the slave drives the write ACK
      i2c_start();
      send_byte(8'hA0, 1'b1, ack);
      chk("rst_dev_ack", ack, 1);
      send_byte(8'h20, 1'b1, ack);
      chk("rst_wa_ack", ack, 1);
      ptr = 8'h20;
      v = 8'($urandom);
      exp_wq.push_back({8'h20, v});
      exp_mem[8'h20] = v;
      for (int i = 7; i >= 0; i--) clock_bit(v[i], 1'b0, s);
      wait_n(6);
      chk("ackwr_oe_on", sda_oe, 1);
      rst_n = 1'b0;
      #1;
      chk("async_oe_off", sda_oe, 0);
      chk("async_addr0", mem_addr, 0);
      chk("async_busy0", busy, 0);
      ptr = 0;
      wait_n(3); sda_m = 1'b1;
      wait_n(2); scl_m = 1'b1;
      wait_n(3); rst_n = 1'b1;
      wait_n(10);
      chk("post_rst_wq", exp_wq.size(), 0);
      dq = '{8'h5C, 8'hC5};
      do_write(7'h50, 8'h30, dq);
      do_read(1'b1, 8'h30, 2, got);

      // randomized traffic
      for (int t = 0; t < 24; t++) begin
         kind = $urandom_range(0, 5);
         case (kind)
            0, 1: begin
               dq.delete();
               repeat ($urandom_range(1, 4)) dq.push_back(8'($urandom));
               do_write(7'h50, 8'($urandom), dq);
            end
            2: do_read(1'b1, 8'($urandom), $urandom_range(1, 4), got);
            3: do_read(1'b0, 8'h00, $urandom_range(1, 4), got);
            4: begin
               v = 8'($urandom_range(0, 127));
               if (v[6:0] == 7'h50) v = 8'h51;
               dq = '{8'hEE};
               do_write(v[6:0], 8'($urandom), dq);
            end
            default: do_partial(8'($urandom));
         endcase
      end

      wait_n(10);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/i2c_eeprom_slave_ctrl.md
# i2c_eeprom_slave_ctrl

I2C slave protocol controller for the EEPROM Avalon slave. It oversamples `scl_in`/`sda_in` in the system clock domain and detects START/STOP. It sequences device-address match, word-address load, byte writes and sequential reads against a synchronous on-chip memory, and drives ACK/read data through an open-drain enable.

## Interface
- `DEV_ADDR`, default 7'h50: 7-bit slave address matched after START.
- `ADDR_W`, default 8: memory word-address width; word-address byte uses its low ADDR_W bits (ADDR_W ≤ 8).
- `PAGE_SIZE`, default 8: page length in bytes, power of two; used only with the page-wrap macro.
- `SYNC_STAGES`, default 2: synchronizer depth on `scl_in`/`sda_in`.

Ports:
- `clk`  in  1  system clock, the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `scl_in`  in  1  raw I2C clock pin.
- `sda_in`  in  1  raw I2C data pin.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release.
- `mem_addr`  out  ADDR_W  current memory address pointer.
- `mem_wdata`  out  8  write byte.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_rdata`  in  8  memory data at `mem_addr`, valid 1 clk after an address change.
- `busy`  out  1  high from address match until STOP or NACK-to-IDLE.

## Operation
- Synchronized SCL/SDA (`s_scl`, `s_sda`) plus one history flop give edge pulses: `scl_rise`, `scl_fall`, `start` (s_sda 1→0 with s_scl=1), `stop` (s_sda 0→1 with s_scl=1).
- `stop` forces IDLE from any state, releases `sda_oe` and clears `busy`. `start` forces DEVADDR from any state (repeated start), clears the bit counter and keeps `mem_addr`.
- The controller samples SDA on `scl_rise` and changes `sda_oe` only on `scl_fall`.
- States:
  - IDLE: wait for `start`.
  - DEVADDR: shift 8 bits MSB first. If bits[7:1]==DEV_ADDR, go to ACK_DEV, latch R/W and assert `busy`. Otherwise go to IGNORE, which waits for `start`/`stop`.
  - ACK_DEV: `sda_oe`=1 for the 9th SCL period. On the ending `scl_fall`, R/W=0 goes to WORDADDR and R/W=1 goes to READ, loading the shift register from `mem_rdata`.
  - WORDADDR: shift 8 bits, then ACK_WA. The ACK drives 1. `mem_addr` loads on the `scl_fall` that starts the ACK. Then go to WRITE.
  - WRITE: shift 8 bits, then ACK_WR. On the `scl_fall` that starts the ACK, `mem_wdata` is set to the byte and `mem_we` pulses for 1 clk. `mem_addr` increments on the next clk. After the ACK, return to WRITE.
  - READ: `sda_oe` = ~bit (MSB first), updated on each `scl_fall`; `sda_oe`=0 during the master ACK slot. Go to RACK.
  - RACK: sample SDA on the 9th `scl_rise`. If 0 (ACK), `mem_addr` increments, and the shift register reloads from `mem_rdata` on the next `scl_fall`; return to READ. If 1 (NACK), release and go to IDLE-wait, i.e. IGNORE with `busy`=0.
- Address increment wraps modulo 2^ADDR_W, or within the page when the macro is set.
- Reset mid-transfer: all state returns to reset values immediately; the bus is released.

## Timing
- Reset values: `sda_oe`=0, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `busy`=0, state IDLE.
- Pin-to-edge-pulse latency: SYNC_STAGES+1 clk.
- `sda_oe` changes 1 clk after the `scl_fall` pulse.
- SCL low time must be ≥ SYNC_STAGES+4 clk so that data set-up holds.
- `mem_addr` is stable ≥ 2 clk before the read-load `scl_fall`.
- If `start` and `scl_rise` occur in the same clk, `start` wins. If `stop` and `start` could coincide, `stop` wins; they cannot coincide on a legal bus.

## Configuration
- `I2C_EEPROM_PAGE_WRAP_EN` defined: write auto-increment wraps within the PAGE_SIZE-aligned page, i.e. the low log2(PAGE_SIZE) bits roll over and the upper bits are held. Reads still wrap over the full array.
- Not defined: writes and reads both increment linearly, wrapping at 2^ADDR_W.

## Test plan
- Write 0x3C to address 0x10 (START, 0xA0, 0x10, 0x3C, STOP). Required: ACK on all three bytes; one `mem_we` with `mem_addr`=0x10 and `mem_wdata`=0x3C; `mem_addr`=0x11 afterwards; `busy` low after STOP.
- Random read: START, 0xA0, 0x10, repeated START, 0xA1, with memory returning 0x3C then 0x5A, master ACK then NACK, STOP. Required: the bus shows 0x3C then 0x5A; `sda_oe` released on the NACK; state IDLE.
- Address mismatch, device byte 0xA2. Required: `sda_oe` stays 0 through the 9th clock; no `mem_we`; `busy`=0.
- Page wrap with macro defined, PAGE_SIZE=8: write 3 bytes starting at 0x16. Required: writes to 0x16, 0x17, 0x10. Without the macro: 0x16, 0x17, 0x18.
- STOP after 4 data bits of a write byte. Required: no `mem_we`; IDLE; `sda_oe`=0.
- Assert `rst_n`=0 during the ACK_WR slot. Required: `sda_oe` drops to 0 asynchronously and `mem_addr`=0; the next full transaction completes normally.
